debounce_bank: RTL
==================

// Module: debounce_bank
// PURPOSE
//  Multi-channel Schmitt-style debouncer, successor of the single-channel trigger.
//  Filters p_channels asynchronous-origin, pre-synchronised inputs (buttons, limit switches).
//  Rise and fall qualification lengths are separate.
//  Sampling follows an external tick strobe, so filter time = count * tick period.
//  Per-channel edge pulses and a bank-wide change flag let downstream logic or an
//  interrupt collector react without edge detectors of its own.
// PARAMETERS
//  p_channels  8  number of independent channels (>=1)
//  p_rise      5  consecutive high ticks needed to go LOW->HIGH (>=1)
//  p_fall      5  consecutive low ticks needed to go HIGH->LOW (>=1)
// PORTS
//  i_clk     in   1           single clock, all logic on rising edge
//  i_rst     in   1           synchronous reset, active-high
//  i_tick    in   1           sample strobe; 1 = evaluate inputs this cycle
//  i_in      in   p_channels  raw inputs, already synchronised to i_clk
//  o_out     out  p_channels  debounced levels
//  o_rise    out  p_channels  1-cycle pulse, first cycle o_out[n] is 1 after LOW
//  o_fall    out  p_channels  1-cycle pulse, first cycle o_out[n] is 0 after HIGH
//  o_stable  out  p_channels  1 when channel state is LOW or HIGH
//  o_change  out  1           OR of all o_rise|o_fall bits, same cycle
// BEHAVIOUR
//  Per-channel state: START, LOW, RISE, HIGH, FALL.
//  Per-channel counter: width $clog2(max(p_rise,p_fall)+1). All outputs are registered.
//  - Reset (takes priority in any state or mid-count): state=START, counter=0, all outputs 0.
//  - Non-tick cycles (i_tick=0): state and counter hold, o_rise/o_fall/o_change are 0.
//  - On a tick, evaluate i_in[n] per state:
//    START: in=1 -> HIGH, in=0 -> LOW. Initial acquisition never pulses o_rise/o_fall.
//    LOW:   in=1 -> counter=1. If p_rise==1, go HIGH with o_rise; else go RISE.
//           in=0 -> stay in LOW.
//    RISE:  in=0 -> LOW, counter=0.
//           in=1 and counter+1==p_rise -> HIGH, counter=0, o_rise.
//           in=1 otherwise -> counter+1.
//    HIGH:  in=0 -> counter=1. If p_fall==1, go LOW with o_fall; else go FALL.
//           in=1 -> stay in HIGH.
//    FALL:  in=1 -> HIGH, counter=0, no pulse.
//           in=0 and counter+1==p_fall -> LOW, counter=0, o_fall.
//           in=0 otherwise -> counter+1.
//  - o_out=1 in HIGH and FALL, 0 in START, LOW and RISE (hysteresis).
//  - o_out, o_rise and o_fall change one clock after the qualifying tick.
//    o_rise/o_fall coincide with the o_out transition cycle.
//  - Illegal state encoding -> START on the next cycle. This is silent, with no pulse.
//  - The counter never exceeds max(p_rise,p_fall). No wrap-around is possible.
//  - Channels are fully independent. Any number of channels may change on one tick.
//  - p_rise or p_fall < 1, or p_channels < 1, fails elaboration with $error.
// TESTING
//  1. Reset, then tick with i_in=8'h0F.
//     -> next cycle o_out=8'h0F, o_stable=8'hFF, o_rise=0, o_change=0.
//  2. p_rise=5: ch0 from LOW, i_in[0]=1 for 5 ticks, 3 idle cycles between ticks.
//     -> o_out[0]=1 and o_rise[0]=1 for one cycle, one clock after tick 5.
//  3. Glitch: ch1 high for 4 ticks then low (p_rise=5).
//     -> o_out[1] stays 0, no o_rise, o_stable[1]=1 again after the low tick.
//  4. ch2 in HIGH, low for 3 ticks then high (p_fall=5).
//     -> o_out[2] stays 1 throughout, state returns to HIGH, no o_fall.
//  5. Channels 3 and 4 qualify rise and fall on the same tick.
//     -> o_rise=8'h08, o_fall=8'h10, o_change=1 for exactly one cycle.
//  6. i_rst asserted mid-RISE (counter=3).
//     -> next cycle all outputs 0. After release, first tick re-acquires without pulses.
//     Repeat with p_rise=1, p_fall=1: edge passes on the first tick.

Source files
------------

// File: rtl/debounce_bank.sv
// Multi-channel Schmitt-style debouncer with separate rise/fall qualification
// lengths, driven by an external sample strobe. Each channel runs its own small
// state machine. All outputs are registered, so levels and edge pulses appear one
// clock after the tick that qualifies them.
module debounce_bank #(
    parameter int p_channels = 8,
    parameter int p_rise     = 5,
    parameter int p_fall     = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tick,
    input  logic [p_channels-1:0] i_in,
    output logic [p_channels-1:0] o_out,
    output logic [p_channels-1:0] o_rise,
    output logic [p_channels-1:0] o_fall,
    output logic [p_channels-1:0] o_stable,
    output logic                  o_change
);

    // The counter only has to reach the longer of the two qualification lengths.
    localparam int max_len_c = (p_rise > p_fall) ? p_rise : p_fall;
    localparam int cw_c      = $clog2(max_len_c + 1);

    localparam logic [cw_c:0]   rise_len_c = (cw_c + 1)'(p_rise);
    localparam logic [cw_c:0]   fall_len_c = (cw_c + 1)'(p_fall);
    localparam logic [cw_c:0]   inc_one_c  = (cw_c + 1)'(1);
    localparam logic [cw_c-1:0] cnt_zero_c = {cw_c{1'b0}};
    localparam logic [cw_c-1:0] cnt_one_c  = cw_c'(1);

    // Bad parameters stop elaboration instead of building a filter that cannot qualify.
    if (p_channels < 1) begin : g_bad_channels
        $error("debounce_bank: p_channels must be >= 1");
    end
    if (p_rise < 1) begin : g_bad_rise
        $error("debounce_bank: p_rise must be >= 1");
    end
    if (p_fall < 1) begin : g_bad_fall
        $error("debounce_bank: p_fall must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_LOW   = 3'd1,
        ST_RISE  = 3'd2,
        ST_HIGH  = 3'd3,
        ST_FALL  = 3'd4
    } state_t;

    state_t            state_r    [p_channels];
    state_t            state_nx_s [p_channels];
    logic [cw_c-1:0]   cnt_r      [p_channels];
    logic [cw_c-1:0]   cnt_nx_s   [p_channels];
    logic [cw_c:0]     cnt_inc_s  [p_channels];

    logic [p_channels-1:0] out_s;
    logic [p_channels-1:0] rise_s;
    logic [p_channels-1:0] fall_s;
    logic [p_channels-1:0] stable_s;
    logic                  change_s;

    logic [p_channels-1:0] out_r;
    logic [p_channels-1:0] rise_r;
    logic [p_channels-1:0] fall_r;
    logic [p_channels-1:0] stable_r;
    logic                  change_r;

    // Per-channel next state, counter and next output values.
    always_comb begin
        rise_s   = {p_channels{1'b0}};
        fall_s   = {p_channels{1'b0}};
        out_s    = {p_channels{1'b0}};
        stable_s = {p_channels{1'b0}};
        for (int n = 0; n < p_channels; n++) begin
            state_nx_s[n] = state_r[n];
            cnt_nx_s[n]   = cnt_r[n];
            cnt_inc_s[n]  = {1'b0, cnt_r[n]} + inc_one_c;
            case (state_r[n])
                ST_START: begin
                    // Initial acquisition takes the raw level without an edge pulse.
                    if (i_tick) begin
                        state_nx_s[n] = i_in[n] ? ST_HIGH : ST_LOW;
                        cnt_nx_s[n]   = cnt_zero_c;
                    end else begin
                        state_nx_s[n] = ST_START;
                    end
                end
                ST_LOW: begin
                    if (i_tick && i_in[n]) begin
                        cnt_nx_s[n] = cnt_one_c;
                        if (p_rise == 1) begin
                            state_nx_s[n] = ST_HIGH;
                            rise_s[n]     = 1'b1;
                        end else begin
                            state_nx_s[n] = ST_RISE;
                        end
                    end else begin
                        state_nx_s[n] = ST_LOW;
                    end
                end
                ST_RISE: begin
                    if (!i_tick) begin
                        state_nx_s[n] = ST_RISE;
                    end else if (!i_in[n]) begin
                        state_nx_s[n] = ST_LOW;
                        cnt_nx_s[n]   = cnt_zero_c;
                    end else if (cnt_inc_s[n] == rise_len_c) begin
                        state_nx_s[n] = ST_HIGH;
                        cnt_nx_s[n]   = cnt_zero_c;
                        rise_s[n]     = 1'b1;
                    end else begin
                        cnt_nx_s[n]   = cnt_inc_s[n][cw_c-1:0];
                    end
                end
                ST_HIGH: begin
                    if (i_tick && !i_in[n]) begin
                        cnt_nx_s[n] = cnt_one_c;
                        if (p_fall == 1) begin
                            state_nx_s[n] = ST_LOW;
                            fall_s[n]     = 1'b1;
                        end else begin
                            state_nx_s[n] = ST_FALL;
                        end
                    end else begin
                        state_nx_s[n] = ST_HIGH;
                    end
                end
                ST_FALL: begin
                    if (!i_tick) begin
                        state_nx_s[n] = ST_FALL;
                    end else if (i_in[n]) begin
                        state_nx_s[n] = ST_HIGH;
                        cnt_nx_s[n]   = cnt_zero_c;
                    end else if (cnt_inc_s[n] == fall_len_c) begin
                        state_nx_s[n] = ST_LOW;
                        cnt_nx_s[n]   = cnt_zero_c;
                        fall_s[n]     = 1'b1;
                    end else begin
                        cnt_nx_s[n]   = cnt_inc_s[n][cw_c-1:0];
                    end
                end
                default: begin
                    // Corrupted encoding: quietly restart acquisition.
                    state_nx_s[n] = ST_START;
                    cnt_nx_s[n]   = cnt_zero_c;
                end
            endcase
            out_s[n]    = (state_nx_s[n] == ST_HIGH) || (state_nx_s[n] == ST_FALL);
            stable_s[n] = (state_nx_s[n] == ST_LOW)  || (state_nx_s[n] == ST_HIGH);
        end
        change_s = |(rise_s | fall_s);
    end

    // State, counters and registered outputs; reset wins over everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int n = 0; n < p_channels; n++) begin
                state_r[n] <= ST_START;
                cnt_r[n]   <= cnt_zero_c;
            end
            out_r    <= {p_channels{1'b0}};
            rise_r   <= {p_channels{1'b0}};
            fall_r   <= {p_channels{1'b0}};
            stable_r <= {p_channels{1'b0}};
            change_r <= 1'b0;
        end else begin
            for (int n = 0; n < p_channels; n++) begin
                state_r[n] <= state_nx_s[n];
                cnt_r[n]   <= cnt_nx_s[n];
            end
            out_r    <= out_s;
            rise_r   <= rise_s;
            fall_r   <= fall_s;
            stable_r <= stable_s;
            change_r <= change_s;
        end
    end

    assign o_out    = out_r;
    assign o_rise   = rise_r;
    assign o_fall   = fall_r;
    assign o_stable = stable_r;
    assign o_change = change_r;

endmodule
